lsu_ctrl: RTL

//  Responder end of the EXU AGU command interface; initiator of the LSU write-back interface.

---
 rtl/lsu_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: AGU command responder that drives the single-port DTCM SRAM and
// returns responses in command order. Loads go out on the write-back port as
// aligned, extended data. Stores are acknowledged on agu_rsp_*.
// Handshake rule for all three channels: a transfer happens on a cycle where
// valid & ready are both 1. A valid output, once raised, keeps its payload
// stable until it is accepted.
module lsu_ctrl #(
  parameter int AW    = 16,
  parameter int ITAGW = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             agu_cmd_valid,
  output logic             agu_cmd_ready,
  input  logic [AW-1:0]    agu_cmd_addr,
  input  logic             agu_cmd_read,
  input  logic [ITAGW-1:0] agu_cmd_itag,
  input  logic [31:0]      agu_cmd_wdata,
  input  logic [3:0]       agu_cmd_wmask,
  input  logic [1:0]       agu_cmd_size,
  input  logic             agu_cmd_usign,
  output logic             agu_rsp_valid,
  input  logic             agu_rsp_ready,
  output logic [31:0]      agu_rsp_rdata,
  output logic             lsu_wbck_o_valid,
  input  logic             lsu_wbck_o_ready,
  output logic [31:0]      lsu_wbck_o_data,
  output logic [ITAGW-1:0] lsu_wbck_o_itag,
  output logic             ram_cs,
  output logic             ram_we,
  output logic [AW-3:0]    ram_addr,
  output logic [3:0]       ram_wem,
  output logic [31:0]      ram_din,
  input  logic [31:0]      ram_dout,
  output logic             lsu_active
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Per-entry state of the outstanding queue
  logic [DEPTH-1:0]            rd_q, rd_d;
  logic [DEPTH-1:0][ITAGW-1:0] itag_q, itag_d;
  logic [DEPTH-1:0][1:0]       size_q, size_d;
  logic [DEPTH-1:0]            usign_q, usign_d;
  logic [DEPTH-1:0][1:0]       off_q, off_d;
  logic [DEPTH-1:0][31:0]      data_q, data_d;
  logic [DEPTH-1:0]            dvld_q, dvld_d;
  logic [PW-1:0]               wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]               count_q, count_d;
  // A load issued last cycle whose SRAM word is on ram_dout now
  logic                        pend_q, pend_d;
  logic [PW-1:0]               pend_idx_q, pend_idx_d;

  logic        accept, pop, head_avail;
  logic [31:0] head_word, shifted, ext_data;
  logic [1:0]  head_off;

  // Command side: ready comes only from registered occupancy; the SRAM is driven on accept
  always_comb begin
    agu_cmd_ready = (count_q != CW'(DEPTH));
    accept        = agu_cmd_valid & agu_cmd_ready;
    ram_cs        = accept;
    ram_we        = accept & ~agu_cmd_read;
    ram_addr      = agu_cmd_addr[AW-1:2];
    ram_wem       = agu_cmd_read ? 4'h0 : agu_cmd_wmask;
    ram_din       = agu_cmd_wdata;
    lsu_active    = (count_q != '0);
    agu_rsp_rdata = 32'h0;
  end

  // Head response: data from the entry, or bypassed from the SRAM the cycle after issue
  always_comb begin
    head_avail = (count_q != '0) &&
                 (dvld_q[rptr_q] || (pend_q && (pend_idx_q == rptr_q)));
    head_word  = dvld_q[rptr_q] ? data_q[rptr_q] : ram_dout;
    head_off   = off_q[rptr_q];
    shifted    = head_word;
    ext_data   = head_word;
    case (size_q[rptr_q])
      2'd0: begin
        shifted  = head_word >> {head_off, 3'b000};
        ext_data = {{24{~usign_q[rptr_q] & shifted[7]}}, shifted[7:0]};
      end
      2'd1: begin
        shifted  = head_word >> {head_off[1], 4'b0000};
        ext_data = {{16{~usign_q[rptr_q] & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        shifted  = head_word;
        ext_data = head_word;
      end
    endcase
    lsu_wbck_o_valid = head_avail & rd_q[rptr_q];
    lsu_wbck_o_data  = ext_data;
    lsu_wbck_o_itag  = itag_q[rptr_q];
    agu_rsp_valid    = head_avail & ~rd_q[rptr_q];
    pop              = (lsu_wbck_o_valid & lsu_wbck_o_ready) |
                       (agu_rsp_valid & agu_rsp_ready);
  end

  // Next state: capture SRAM data for the pending load, allocate on accept, advance on pop
  always_comb begin
    rd_d       = rd_q;
    itag_d     = itag_q;
    size_d     = size_q;
    usign_d    = usign_q;
    off_d      = off_q;
    data_d     = data_q;
    dvld_d     = dvld_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    pend_d     = accept & agu_cmd_read;
    pend_idx_d = wptr_q;
    if (pend_q) begin
      data_d[pend_idx_q] = ram_dout;
      dvld_d[pend_idx_q] = 1'b1;
    end
    if (accept) begin
      rd_d[wptr_q]    = agu_cmd_read;
      itag_d[wptr_q]  = agu_cmd_itag;
      size_d[wptr_q]  = agu_cmd_size;
      usign_d[wptr_q] = agu_cmd_usign;
      off_d[wptr_q]   = agu_cmd_addr[1:0];
      data_d[wptr_q]  = 32'h0;
      dvld_d[wptr_q]  = ~agu_cmd_read;
      wptr_d          = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    count_d = count_q + CW'(accept) - CW'(pop);
  end

  // State registers; reset drops every entry and any in-flight SRAM read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q       <= '0;
      itag_q     <= '0;
      size_q     <= '0;
      usign_q    <= '0;
      off_q      <= '0;
      data_q     <= '0;
      dvld_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
    end else begin
      rd_q       <= rd_d;
      itag_q     <= itag_d;
      size_q     <= size_d;
      usign_q    <= usign_d;
      off_q      <= off_d;
      data_q     <= data_d;
      dvld_q     <= dvld_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      pend_q     <= pend_d;
      pend_idx_q <= pend_idx_d;
    end
  end

endmodule
